// File: rtl/ld_st_issue_queue.sv
// Age-ordered load/store reservation station: circular buffer with CDB wakeup,
// oldest-eligible issue, branch-mask squash with tail rollback.
module ld_st_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int CDB_NUM   = 2,
    parameter int PREG_W    = 6,
    parameter int BR_NUM    = 4,
    parameter int PAYLOAD_W = 64,
    parameter int LD_BYPASS = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic                      disp_is_store,
    input  logic [PREG_W-1:0]         disp_ps1,
    input  logic [PREG_W-1:0]         disp_ps2,
    input  logic                      disp_ps1_rdy,
    input  logic                      disp_ps2_rdy,
    input  logic [BR_NUM-1:0]         disp_br_mask,
    input  logic [PAYLOAD_W-1:0]      disp_payload,
    input  logic [CDB_NUM-1:0]        cdb_valid,
    input  logic [CDB_NUM*PREG_W-1:0] cdb_pd,
    input  logic                      br_valid,
    input  logic [$clog2(BR_NUM)-1:0] br_idx,
    input  logic                      br_mispredict,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic                      iss_is_store,
    output logic [PAYLOAD_W-1:0]      iss_payload,
    output logic [BR_NUM-1:0]         iss_br_mask,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_is_store;
    logic [DEPTH-1:0]     r_ps1_rdy;
    logic [DEPTH-1:0]     r_ps2_rdy;
    logic [PREG_W-1:0]    r_ps1     [DEPTH];
    logic [PREG_W-1:0]    r_ps2     [DEPTH];
    logic [BR_NUM-1:0]    r_br_mask [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic                 r_hold;
    logic [AW-1:0]        r_hold_idx;

    logic                 w_squash;
    logic                 w_resolve;
    logic [BR_NUM-1:0]    w_clr_mask;
    logic [PW-1:0]        w_occ;
    logic                 w_full;
    logic                 w_disp_fire;
    logic                 w_iss_fire;
    logic                 w_disp_hit1;
    logic                 w_disp_hit2;
    logic [DEPTH-1:0]     w_wake1;
    logic [DEPTH-1:0]     w_wake2;
    logic [DEPTH-1:0]     w_kill;
    logic                 w_scan_found;
    logic [AW-1:0]        w_scan_idx;
    logic                 w_iss_found;
    logic [AW-1:0]        w_iss_idx;
    logic [DEPTH-1:0]     w_valid_next;
    logic [PW-1:0]        w_head_next;
    logic [PW-1:0]        w_tail_next;

    function automatic logic cdb_match(input logic [PREG_W-1:0]         tag,
                                       input logic [CDB_NUM-1:0]        vld,
                                       input logic [CDB_NUM*PREG_W-1:0] pd);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_NUM; c++) begin
            if (vld[c] && pd[c*PREG_W +: PREG_W] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    assign w_squash    = br_valid && br_mispredict;
    assign w_resolve   = br_valid && !br_mispredict;
    assign w_clr_mask  = w_resolve ? (BR_NUM'(1) << br_idx) : '0;
    assign w_occ       = r_tail - r_head;
    assign w_full      = (w_occ == PW'(DEPTH));
    assign disp_ready  = !w_full && !w_squash;
    assign occupancy   = w_occ;
    assign w_disp_fire = disp_valid && disp_ready;
    assign w_disp_hit1 = cdb_match(disp_ps1, cdb_valid, cdb_pd);
    assign w_disp_hit2 = cdb_match(disp_ps2, cdb_valid, cdb_pd);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign w_wake1[gi] = cdb_match(r_ps1[gi], cdb_valid, cdb_pd);
        assign w_wake2[gi] = cdb_match(r_ps2[gi], cdb_valid, cdb_pd);
        assign w_kill[gi]  = w_squash && r_br_mask[gi][br_idx];
    end

    // Oldest-first scan; ordering constraints see every older valid entry,
    // including ones being killed this cycle.
    always_comb begin : p_scan
        logic          older_valid;
        logic          older_store;
        logic [AW-1:0] pos;
        older_valid  = 1'b0;
        older_store  = 1'b0;
        pos          = '0;
        w_scan_found = 1'b0;
        w_scan_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = r_head[AW-1:0] + AW'(k);
            if (PW'(k) < w_occ && r_valid[pos]) begin
                if (!w_scan_found && r_ps1_rdy[pos] && r_ps2_rdy[pos] && !w_kill[pos] &&
                    (r_is_store[pos] ? !older_valid : (LD_BYPASS != 0 || !older_store))) begin
                    w_scan_found = 1'b1;
                    w_scan_idx   = pos;
                end
                older_valid = 1'b1;
                if (r_is_store[pos]) older_store = 1'b1;
            end
        end
    end

    // A stalled candidate stays selected so the consumer sees a stable offer.
    always_comb begin : p_select
        w_iss_found = w_scan_found;
        w_iss_idx   = w_scan_idx;
        if (r_hold && r_valid[r_hold_idx] && !w_kill[r_hold_idx]) begin
            w_iss_found = 1'b1;
            w_iss_idx   = r_hold_idx;
        end
    end

    assign iss_valid    = w_iss_found;
    assign iss_is_store = r_is_store[w_iss_idx];
    assign iss_payload  = r_payload[w_iss_idx];
    assign iss_br_mask  = r_br_mask[w_iss_idx] & ~w_clr_mask;
    assign w_iss_fire   = w_iss_found && iss_ready;

    always_comb begin : p_next
        logic [PW-1:0] tail_adv;
        logic [PW-1:0] span;
        logic          first_found;
        logic [PW-1:0] first_off;
        logic [PW-1:0] last_off;
        logic [AW-1:0] pos;
        w_valid_next = r_valid & ~w_kill;
        if (w_iss_fire)  w_valid_next[w_iss_idx] = 1'b0;
        if (w_disp_fire) w_valid_next[r_tail[AW-1:0]] = 1'b1;
        tail_adv    = r_tail + PW'(w_disp_fire);
        span        = tail_adv - r_head;
        first_found = 1'b0;
        first_off   = '0;
        last_off    = '0;
        pos         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = r_head[AW-1:0] + AW'(k);
            if (PW'(k) < span && w_valid_next[pos]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_off   = PW'(k);
                end
                last_off = PW'(k);
            end
        end
        if (first_found) begin
            w_head_next = r_head + first_off;
            w_tail_next = w_squash ? (r_head + last_off + PW'(1)) : tail_adv;
        end else if (w_squash) begin
            w_head_next = r_head;
            w_tail_next = r_head;
        end else begin
            w_head_next = tail_adv;
            w_tail_next = tail_adv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
        end else begin
            r_valid    <= w_valid_next;
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
            r_hold     <= w_iss_found && !iss_ready;
            r_hold_idx <= w_iss_idx;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_disp_fire && r_tail[AW-1:0] == AW'(i)) begin
                r_is_store[i] <= disp_is_store;
                r_ps1[i]      <= disp_ps1;
                r_ps2[i]      <= disp_ps2;
                r_ps1_rdy[i]  <= disp_ps1_rdy || w_disp_hit1;
                r_ps2_rdy[i]  <= disp_ps2_rdy || w_disp_hit2;
                r_br_mask[i]  <= disp_br_mask & ~w_clr_mask;
                r_payload[i]  <= disp_payload;
            end else begin
                if (w_wake1[i]) r_ps1_rdy[i] <= 1'b1;
                if (w_wake2[i]) r_ps2_rdy[i] <= 1'b1;
                r_br_mask[i] <= r_br_mask[i] & ~w_clr_mask;
            end
        end
    end

endmodule

// File: tb/tb_ld_st_issue_queue.sv
// Scoreboard bench for ld_st_issue_queue; a second instance with LD_BYPASS=1
// shares the stimulus for the load-over-store case.
module tb_ld_st_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid;
    logic        disp_is_store;
    logic [5:0]  disp_ps1;
    logic [5:0]  disp_ps2;
    logic        disp_ps1_rdy;
    logic        disp_ps2_rdy;
    logic [3:0]  disp_br_mask;
    logic [63:0] disp_payload;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_pd;
    logic        br_valid;
    logic [1:0]  br_idx;
    logic        br_mispredict;
    logic        iss_ready;

    logic        disp_ready,   b_disp_ready;
    logic        iss_valid,    b_iss_valid;
    logic        iss_is_store, b_iss_is_store;
    logic [63:0] iss_payload,  b_iss_payload;
    logic [3:0]  iss_br_mask,  b_iss_br_mask;
    logic [3:0]  occupancy,    b_occupancy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    ld_st_issue_queue #(.LD_BYPASS(0)) u_dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_store(disp_is_store),
        .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_ps1_rdy(disp_ps1_rdy),
        .disp_ps2_rdy(disp_ps2_rdy), .disp_br_mask(disp_br_mask), .disp_payload(disp_payload),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .br_valid(br_valid), .br_idx(br_idx), .br_mispredict(br_mispredict),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_is_store(iss_is_store),
        .iss_payload(iss_payload), .iss_br_mask(iss_br_mask), .occupancy(occupancy)
    );

    ld_st_issue_queue #(.LD_BYPASS(1)) u_dut_byp (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(b_disp_ready), .disp_is_store(disp_is_store),
        .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_ps1_rdy(disp_ps1_rdy),
        .disp_ps2_rdy(disp_ps2_rdy), .disp_br_mask(disp_br_mask), .disp_payload(disp_payload),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .br_valid(br_valid), .br_idx(br_idx), .br_mispredict(br_mispredict),
        .iss_valid(b_iss_valid), .iss_ready(iss_ready), .iss_is_store(b_iss_is_store),
        .iss_payload(b_iss_payload), .iss_br_mask(b_iss_br_mask), .occupancy(b_occupancy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every accepted issue of the main instance is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && iss_valid && iss_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_issue", 64'(sb_q.size()), 64'd1);
            end else begin
                logic [63:0] exp;
                exp = sb_q.pop_front();
                $display("[%0t] issue payload=%0h store=%0d mask=%b exp=%0h",
                         $time, iss_payload, iss_is_store, iss_br_mask, exp);
                check_val("issue_payload", iss_payload, exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        disp_valid    = 1'b0;
        cdb_valid     = 2'b00;
        cdb_pd        = '0;
        br_valid      = 1'b0;
        br_mispredict = 1'b0;
        br_idx        = 2'd0;
    endtask

    task automatic set_disp(input logic st, input logic [5:0] p1, input logic r1,
                            input logic [5:0] p2, input logic r2,
                            input logic [3:0] m, input logic [63:0] pl);
        disp_valid    = 1'b1;
        disp_is_store = st;
        disp_ps1      = p1;
        disp_ps1_rdy  = r1;
        disp_ps2      = p2;
        disp_ps2_rdy  = r2;
        disp_br_mask  = m;
        disp_payload  = pl;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        set_disp(1'b0, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0, 64'd0);
        disp_valid = 1'b0;
        iss_ready  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check_val("rst_iss_valid", 64'(iss_valid), 64'd0);
        check_val("rst_occupancy", 64'(occupancy), 64'd0);
        check_val("rst_disp_ready", 64'(disp_ready), 64'd1);

        // Fill with 8 ready loads, then drain one per cycle in order.
        for (int i = 0; i < 8; i++) begin
            check_val("fill_disp_ready", 64'(disp_ready), 64'd1);
            set_disp(1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 4'd0, 64'h10 + 64'(i));
            sb_q.push_back(64'h10 + 64'(i));
            tick();
        end
        idle();
        check_val("full_occupancy", 64'(occupancy), 64'd8);
        check_val("full_disp_ready", 64'(disp_ready), 64'd0);
        check_val("full_iss_payload", iss_payload, 64'h10);
        iss_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val("drain_occupancy", 64'(occupancy), 64'(7 - k));
            check_val("drain_disp_ready", 64'(disp_ready), 64'd1);
        end
        check_val("drain_iss_valid", 64'(iss_valid), 64'd0);

        // Store waiting on tag 5 ahead of a ready load.
        set_disp(1'b1, 6'd0, 1'b1, 6'd5, 1'b0, 4'd0, 64'h100);
        tick();
        set_disp(1'b0, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0, 64'h101);
        tick();
        idle();
        check_val("st_block_iss_valid", 64'(iss_valid), 64'd0);
        check_val("st_block_occupancy", 64'(occupancy), 64'd2);
        check_val("byp_ld_iss_valid", 64'(b_iss_valid), 64'd1);
        check_val("byp_ld_payload", b_iss_payload, 64'h101);
        tick();
        check_val("st_block_iss_valid2", 64'(iss_valid), 64'd0);
        sb_q.push_back(64'h100);
        sb_q.push_back(64'h101);
        cdb_valid = 2'b10;
        cdb_pd    = {6'd5, 6'd0};
        tick();
        idle();
        check_val("st_wake_iss_valid", 64'(iss_valid), 64'd1);
        check_val("st_wake_is_store", 64'(iss_is_store), 64'd1);
        check_val("byp_st_iss_valid", 64'(b_iss_valid), 64'd1);
        check_val("byp_st_payload", b_iss_payload, 64'h100);
        check_val("byp_st_mask", 64'(b_iss_br_mask), 64'd0);
        tick();
        check_val("ld_after_st_is_store", 64'(iss_is_store), 64'd0);
        tick();
        check_val("st_ld_empty_occ", 64'(occupancy), 64'd0);
        check_val("byp_empty_occ", 64'(b_occupancy), 64'd0);
        check_val("byp_disp_ready", 64'(b_disp_ready), 64'd1);

        // Dispatch-cycle CDB bypass.
        cdb_valid = 2'b01;
        cdb_pd    = {6'd0, 6'd7};
        set_disp(1'b0, 6'd7, 1'b0, 6'd0, 1'b1, 4'd0, 64'h200);
        sb_q.push_back(64'h200);
        tick();
        idle();
        check_val("disp_byp_iss_valid", 64'(iss_valid), 64'd1);
        check_val("disp_byp_payload", iss_payload, 64'h200);
        tick();
        check_val("disp_byp_empty_occ", 64'(occupancy), 64'd0);

        // Mispredict on branch 1 drops the two dependent entries.
        iss_ready = 1'b0;
        set_disp(1'b0, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0000, 64'h300); tick();
        set_disp(1'b0, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0010, 64'h301); tick();
        set_disp(1'b0, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0010, 64'h302); tick();
        idle();
        check_val("mp_pre_occ", 64'(occupancy), 64'd3);
        br_valid      = 1'b1;
        br_mispredict = 1'b1;
        br_idx        = 2'd1;
        #1;
        check_val("mp_disp_ready", 64'(disp_ready), 64'd0);
        check_val("mp_iss_valid", 64'(iss_valid), 64'd1);
        tick();
        idle();
        check_val("mp_post_occ", 64'(occupancy), 64'd1);
        set_disp(1'b0, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0000, 64'h303);
        tick();
        idle();
        check_val("mp_redisp_occ", 64'(occupancy), 64'd2);
        sb_q.push_back(64'h300);
        sb_q.push_back(64'h303);
        iss_ready = 1'b1;
        repeat (2) tick();
        check_val("mp_empty_occ", 64'(occupancy), 64'd0);

        // Correct resolve on branch 1 clears masks, drops nothing.
        iss_ready = 1'b0;
        set_disp(1'b0, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0010, 64'h310); tick();
        set_disp(1'b0, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0010, 64'h311); tick();
        set_disp(1'b0, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0000, 64'h312); tick();
        idle();
        check_val("cr_mask_before", 64'(iss_br_mask), 64'b0010);
        br_valid = 1'b1;
        br_idx   = 2'd1;
        #1;
        check_val("cr_mask_same_cycle", 64'(iss_br_mask), 64'd0);
        check_val("cr_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        idle();
        check_val("cr_occ", 64'(occupancy), 64'd3);
        check_val("cr_mask_stored", 64'(iss_br_mask), 64'd0);
        sb_q.push_back(64'h310);
        sb_q.push_back(64'h311);
        sb_q.push_back(64'h312);
        iss_ready = 1'b1;
        repeat (3) tick();
        check_val("cr_empty_occ", 64'(occupancy), 64'd0);

        // Full queue stalled, then full-and-issue dispatch rejection, then reset.
        iss_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_disp(1'b0, 6'd3, 1'b1, 6'd4, 1'b1, 4'd0, 64'h400 + 64'(i));
            sb_q.push_back(64'h400 + 64'(i));
            tick();
        end
        idle();
        check_val("stall_occ", 64'(occupancy), 64'd8);
        for (int c = 0; c < 3; c++) begin
            check_val("stall_payload", iss_payload, 64'h400);
            tick();
        end
        iss_ready = 1'b1;
        set_disp(1'b0, 6'd3, 1'b1, 6'd4, 1'b1, 4'd0, 64'hBAD);
        #1;
        check_val("full_issue_disp_ready", 64'(disp_ready), 64'd0);
        tick();
        idle();
        check_val("full_issue_occ", 64'(occupancy), 64'd7);
        rst = 1'b1;
        tick();
        check_val("midrst_iss_valid", 64'(iss_valid), 64'd0);
        check_val("midrst_occ", 64'(occupancy), 64'd0);
        check_val("midrst_disp_ready", 64'(disp_ready), 64'd1);
        rst = 1'b0;
        sb_q.delete();
        tick();
        check_val("post_rst_iss_valid", 64'(iss_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
